// File: rtl/pc_next_if.sv
// Fetch-stage PC bus: redirect requests in, fetch PC and status out.
// master drives the requests; slave (pc_next_unit) returns the PC state.
interface pc_next_if;
  logic        stall_in;
  logic        jump_in;
  logic [27:0] jump_target28_in;
  logic        branch_in;
  logic [31:0] branch_offset_in;
  logic        jr_in;
  logic [31:0] jr_addr_in;
  logic [31:0] redir_pc4_in;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic        fetch_req_out;
  logic        pending_out;
  logic        align_err_out;

  modport master (
    output stall_in, jump_in, jump_target28_in, branch_in, branch_offset_in,
           jr_in, jr_addr_in, redir_pc4_in,
    input  pc_out, pc_plus4_out, fetch_req_out, pending_out, align_err_out
  );

  modport slave (
    input  stall_in, jump_in, jump_target28_in, branch_in, branch_offset_in,
           jr_in, jr_addr_in, redir_pc4_in,
    output pc_out, pc_plus4_out, fetch_req_out, pending_out, align_err_out
  );
endinterface

// File: rtl/pc_next_unit.sv
// Program counter and next-PC selection with stall hold and pending redirect.
// Optional PC_ALIGN_CHECK_EN adds a sticky misaligned-JR flag.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic     clk,
  input logic     rst,
  pc_next_if.slave bus
);

  typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pend_target_reg, pend_target_next;
  logic        pend_valid_reg, pend_valid_next;

  logic [31:0] jump_target, branch_target, jr_target;
  logic [31:0] redir_target;
  logic        redir_valid;

  assign jump_target   = {bus.redir_pc4_in[31:28], bus.jump_target28_in};
  assign branch_target = bus.redir_pc4_in + {bus.branch_offset_in[29:0], 2'b00};
  assign jr_target     = {bus.jr_addr_in[31:2], 2'b00};

  // Lower-priority requests in the same cycle are simply dropped.
  always_comb begin
    redir_valid  = bus.jr_in | bus.jump_in | bus.branch_in;
    redir_target = branch_target;
    if (bus.jr_in) begin
      redir_target = jr_target;
    end else if (bus.jump_in) begin
      redir_target = jump_target;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    pend_valid_next  = pend_valid_reg;
    pend_target_next = pend_target_reg;
    case (state_reg)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        if (bus.stall_in) begin
          state_next = STALL;
          if (redir_valid) begin
            pend_valid_next  = 1'b1;
            pend_target_next = redir_target;
          end
        end else if (redir_valid) begin
          pc_next = redir_target;
        end else begin
          pc_next = pc_reg + 32'd4;
        end
      end
      STALL: begin
        if (bus.stall_in) begin
          if (redir_valid) begin
            pend_valid_next  = 1'b1;
            pend_target_next = redir_target;
          end
        end else begin
          // A fresh redirect on the release cycle beats the older pending one.
          if (redir_valid) begin
            pc_next = redir_target;
          end else if (pend_valid_reg) begin
            pc_next = pend_target_reg;
          end else begin
            pc_next = pc_reg + 32'd4;
          end
          pend_valid_next = 1'b0;
          state_next      = RUN;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= BOOT;
      pc_reg          <= RESET_PC;
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= 32'h0000_0000;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pend_valid_reg  <= pend_valid_next;
      pend_target_reg <= pend_target_next;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic align_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      align_err_reg <= 1'b0;
    end else if (bus.jr_in && (bus.jr_addr_in[1:0] != 2'b00)) begin
      align_err_reg <= 1'b1;
    end
  end

  assign bus.align_err_out = align_err_reg;
`else
  assign bus.align_err_out = 1'b0;
`endif

  assign bus.pc_out        = pc_reg;
  assign bus.pc_plus4_out  = pc_reg + 32'd4;
  assign bus.fetch_req_out = (state_reg == RUN);
  assign bus.pending_out   = pend_valid_reg;

endmodule
